param_deser_queue: RTL and testbench



---
 rtl/param_deser_pkg.sv | 15 +
 rtl/param_deser_queue_sync_fifo.sv | 79 +++++++
 rtl/param_deser_queue.sv | 113 +++++++++++
 tb/tb_param_deser_queue.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_deser_pkg.sv
// Shared types and helpers for the parametrised serial-to-word queue.
package param_deser_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PUSH    = 2'd1,
        STALL   = 2'd2
    } deser_state_e;

    // Width needed to count 0..depth inclusive.
    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/param_deser_queue_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo
    import param_deser_pkg::*;
#(
    parameter  int WORD_W = 8,
    parameter  int DEPTH  = 8,
    localparam int LEN_W  = len_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              push_ready_o,
    output logic [WORD_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign empty        = (len_q == '0);
    assign full_o       = (len_q == LEN_W'(DEPTH));
    assign do_pop       = pop_i && !empty;
    assign push_ready_o = !full_o || do_pop;
    assign do_push      = push_i && push_ready_o;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            len_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   len_d = len_q + LEN_W'(1);
                2'b01:   len_d = len_q - LEN_W'(1);
                default: len_d = len_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
        end
    end

    // NOTE: storage is deliberately not reset; len_q gates every read so stale words never escape.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = empty ? '0 : mem_q[rd_ptr_q];
    assign len_o  = len_q;

endmodule

// File: rtl/param_deser_queue.sv
// Serial bit collector feeding a word FIFO: edge-detected strobes, configurable
// bit order, backpressure with a held word, sticky drop flag and synchronous flush.
module param_deser_queue
    import param_deser_pkg::*;
#(
    parameter  int WORD_W    = 8,
    parameter  int DEPTH     = 8,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int LEN_W     = len_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_in,
    input  logic              data_in,
    input  logic              write_in,
    output logic              status_out,
    input  logic              dequeue_in,
    output logic [WORD_W-1:0] data_out,
    output logic [LEN_W-1:0]  len_out,
    output logic              full_out,
    output logic              drop_out
);

    localparam int CNT_W = $clog2(WORD_W);

    deser_state_e      state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              drop_q, drop_d;
    logic              write_q;
    logic              deq_q;
    logic              wr_rise;
    logic              deq_rise;
    logic              push;
    logic              push_ready;

    assign wr_rise  = write_in & ~write_q;
    assign deq_rise = dequeue_in & ~deq_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        drop_d    = drop_q;
        push      = 1'b0;
        if (clear_in) begin
            state_d   = COLLECT;
            bit_cnt_d = '0;
            shift_d   = '0;
            drop_d    = 1'b0;
        end else begin
            if (wr_rise && state_q != COLLECT) drop_d = 1'b1;
            unique case (state_q)
                COLLECT: begin
                    if (wr_rise) begin
                        shift_d = MSB_FIRST ? {shift_q[WORD_W-2:0], data_in}
                                            : {data_in, shift_q[WORD_W-1:1]};
                        if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = PUSH;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                PUSH, STALL: begin
                    push    = 1'b1;
                    state_d = push_ready ? COLLECT : STALL;
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    // Edge registers power up high so a strobe held through reset is not an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q   <= 1'b1;
            deq_q     <= 1'b1;
            state_q   <= COLLECT;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            drop_q    <= 1'b0;
        end else begin
            write_q   <= write_in;
            deq_q     <= dequeue_in;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            drop_q    <= drop_d;
        end
    end

    sync_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i        (clock),
        .rst_i        (reset),
        .clear_i      (clear_in),
        .push_i       (push),
        .pop_i        (deq_rise),
        .data_i       (shift_q),
        .push_ready_o (push_ready),
        .data_o       (data_out),
        .len_o        (len_out),
        .full_o       (full_out)
    );

    assign status_out = (state_q == COLLECT);
    assign drop_out   = drop_q;

endmodule

// File: tb/tb_param_deser_queue.sv
// Bench for param_deser_queue: an 8x8 MSB-first instance and a 4x4 LSB-first instance,
// each compared against a transaction-level queue model.
module tb_param_deser_queue;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       a_clear, a_data, a_write, a_deq;
    logic       a_status, a_full, a_drop;
    logic [7:0] a_dout;
    logic [3:0] a_len;
    logic       b_clear, b_data, b_write, b_deq;
    logic       b_status, b_full, b_drop;
    logic [3:0] b_dout;
    logic [2:0] b_len;

    param_deser_queue #(.WORD_W(8), .DEPTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clock      (clock),
        .reset      (reset),
        .clear_in   (a_clear),
        .data_in    (a_data),
        .write_in   (a_write),
        .status_out (a_status),
        .dequeue_in (a_deq),
        .data_out   (a_dout),
        .len_out    (a_len),
        .full_out   (a_full),
        .drop_out   (a_drop)
    );

    param_deser_queue #(.WORD_W(4), .DEPTH(4), .MSB_FIRST(1'b0)) dut_b (
        .clock      (clock),
        .reset      (reset),
        .clear_in   (b_clear),
        .data_in    (b_data),
        .write_in   (b_write),
        .status_out (b_status),
        .dequeue_in (b_deq),
        .data_out   (b_dout),
        .len_out    (b_len),
        .full_out   (b_full),
        .drop_out   (b_drop)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: words queued, the word waiting for space, and the sticky drop flag.
    int mq0[$];
    int mq1[$];
    int m_acc[2], m_held_v[2], m_held[2], m_drop[2], m_bits[2], m_part[2];

    function automatic int ww(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic int qfront(input int d);
        return (d == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic qpush(input int d, input int w);
        if (d == 0) mq0.push_back(w);
        else        mq1.push_back(w);
    endtask

    task automatic qpop(input int d);
        if (d == 0) void'(mq0.pop_front());
        else        void'(mq1.pop_front());
    endtask

    task automatic model_reset(input int d);
        if (d == 0) mq0.delete();
        else        mq1.delete();
        m_acc[d]    = 1;
        m_held_v[d] = 0;
        m_held[d]   = 0;
        m_drop[d]   = 0;
        m_bits[d]   = 0;
        m_part[d]   = 0;
    endtask

    task automatic model_bit(input int d, input int b);
        if (m_acc[d] == 0) begin
            m_drop[d] = 1;
        end else begin
            if (d == 0) m_part[d] = (m_part[d] << 1) | b;
            else        m_part[d] = m_part[d] | (b << m_bits[d]);
            m_bits[d]++;
            if (m_bits[d] == ww(d)) begin
                if (qsize(d) < ww(d)) begin
                    qpush(d, m_part[d]);
                end else begin
                    m_held[d]   = m_part[d];
                    m_held_v[d] = 1;
                    m_acc[d]    = 0;
                end
                m_bits[d] = 0;
                m_part[d] = 0;
            end
        end
    endtask

    task automatic model_pop(input int d);
        if (qsize(d) > 0) begin
            qpop(d);
            if (m_held_v[d] != 0) begin
                qpush(d, m_held[d]);
                m_held_v[d] = 0;
                m_acc[d]    = 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_bit(input int d, input int b, input int hi, input int lo);
        logic bv;
        bv = b[0];
        if (d == 0) begin a_data = bv; a_write = 1'b1; end
        else        begin b_data = bv; b_write = 1'b1; end
        tick(hi);
        if (d == 0) a_write = 1'b0;
        else        b_write = 1'b0;
        tick(lo);
        model_bit(d, b);
    endtask

    task automatic send_word(input int d, input int w);
        int sh;
        for (int i = 0; i < ww(d); i++) begin
            sh = (d == 0) ? (7 - i) : i;
            drive_bit(d, (w >> sh) & 1, $urandom_range(1, 12), $urandom_range(3, 6));
        end
    endtask

    task automatic do_pop(input int d, input int hi, input int lo);
        if (d == 0) a_deq = 1'b1;
        else        b_deq = 1'b1;
        tick(hi);
        if (d == 0) a_deq = 1'b0;
        else        b_deq = 1'b0;
        tick(lo);
        model_pop(d);
    endtask

    task automatic check_all(input int d, input string tag);
        int exp_head;
        int exp_full;
        exp_head = (qsize(d) > 0) ? qfront(d) : 0;
        exp_full = (qsize(d) == ww(d)) ? 1 : 0;
        if (d == 0) begin
            check({tag, ".data"},   32'(a_dout),   exp_head);
            check({tag, ".len"},    32'(a_len),    qsize(d));
            check({tag, ".full"},   32'(a_full),   exp_full);
            check({tag, ".status"}, 32'(a_status), m_acc[d]);
            check({tag, ".drop"},   32'(a_drop),   m_drop[d]);
        end else begin
            check({tag, ".data"},   32'(b_dout),   exp_head);
            check({tag, ".len"},    32'(b_len),    qsize(d));
            check({tag, ".full"},   32'(b_full),   exp_full);
            check({tag, ".status"}, 32'(b_status), m_acc[d]);
            check({tag, ".drop"},   32'(b_drop),   m_drop[d]);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        model_reset(0);
        model_reset(1);
    endtask

    initial begin
        reset   = 1'b1;
        a_clear = 1'b0; a_data = 1'b0; a_write = 1'b0; a_deq = 1'b0;
        b_clear = 1'b0; b_data = 1'b0; b_write = 1'b0; b_deq = 1'b0;
        model_reset(0);
        model_reset(1);
        tick(3);
        reset = 1'b0;
        tick(2);
        check_all(0, "rst_a");
        check_all(1, "rst_b");

        // First word 8'h80 with 10-cycle pulses, checking the one-cycle push latency.
        drive_bit(0, 1, 10, 3);
        for (int i = 0; i < 6; i++) drive_bit(0, 0, 10, 3);
        a_data  = 1'b0;
        a_write = 1'b1;
        tick(1);
        check("lat.status_push", 32'(a_status), 0);
        check("lat.len_before", 32'(a_len), 0);
        tick(1);
        check("lat.len_after", 32'(a_len), 1);
        check("lat.status_back", 32'(a_status), 1);
        tick(8);
        a_write = 1'b0;
        tick(3);
        model_bit(0, 0);
        check("first.data", 32'(a_dout), 32'h80);
        check_all(0, "first");

        // Fill to full, then a ninth word stalls and further bits are dropped.
        for (int w = 8'h81; w <= 8'h87; w++) send_word(0, w);
        check_all(0, "full");
        send_word(0, 8'h88);
        check_all(0, "stall");
        drive_bit(0, 1, 4, 3);
        drive_bit(0, 0, 4, 3);
        check_all(0, "drop");

        // One long dequeue pulse pops once and releases the held word.
        do_pop(0, 200, 3);
        check("longpop.data", 32'(a_dout), 32'h81);
        check_all(0, "longpop");

        for (int i = 0; i < 8; i++) begin
            do_pop(0, $urandom_range(1, 15), 3);
            check_all(0, "drain");
        end
        do_pop(0, 5, 3);
        check_all(0, "empty_pop");

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) send_word(0, $urandom_range(0, 255));
            else                           do_pop(0, $urandom_range(1, 20), $urandom_range(3, 6));
            check_all(0, "rand_a");
        end

        // LSB-first 4-bit instance: bits 1,0,0,0 give 4'h1, then wrap the pointers.
        drive_bit(1, 1, 3, 3);
        drive_bit(1, 0, 3, 3);
        drive_bit(1, 0, 3, 3);
        drive_bit(1, 0, 3, 3);
        check("b_first.data", 32'(b_dout), 32'h1);
        check_all(1, "b_first");
        do_pop(1, 2, 3);
        for (int i = 0; i < 6; i++) begin
            send_word(1, $urandom_range(0, 15));
            send_word(1, $urandom_range(0, 15));
            check_all(1, "wrap_push");
            do_pop(1, $urandom_range(1, 8), 3);
            do_pop(1, $urandom_range(1, 8), 3);
            check_all(1, "wrap_pop");
        end
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0) send_word(1, $urandom_range(0, 15));
            else                           do_pop(1, $urandom_range(1, 20), $urandom_range(3, 6));
            check_all(1, "rand_b");
        end

        // Reset after five bits discards the partial word.
        pulse_reset();
        for (int i = 0; i < 5; i++) drive_bit(0, 1, 2, 3);
        pulse_reset();
        check_all(0, "rst_mid");
        check_all(1, "rst_mid_b");
        send_word(0, 8'h3C);
        check("rst_mid.word", 32'(a_dout), 32'h3C);
        check_all(0, "rst_mid_word");

        // Flush with three words queued, drop set and a partial word in flight.
        pulse_reset();
        for (int i = 0; i < 9; i++) send_word(0, $urandom_range(0, 255));
        drive_bit(0, 1, 3, 3);
        for (int i = 0; i < 6; i++) do_pop(0, 2, 3);
        check_all(0, "pre_clear");
        for (int i = 0; i < 3; i++) drive_bit(0, 1, 2, 3);
        a_clear = 1'b1;
        tick(1);
        a_clear = 1'b0;
        model_reset(0);
        tick(4);
        check_all(0, "clear");
        send_word(0, 8'hC3);
        check("clear.word", 32'(a_dout), 32'hC3);
        check_all(0, "clear_word");

        // Strobes held high through reset must not register as edges.
        reset   = 1'b1;
        a_data  = 1'b1;
        a_write = 1'b1;
        a_deq   = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);
        model_reset(0);
        model_reset(1);
        check_all(0, "held_rst");
        a_write = 1'b0;
        tick(3);
        send_word(0, 8'h5A);
        check("held_rst.word", 32'(a_dout), 32'h5A);
        check_all(0, "held_rst_word");
        a_deq = 1'b0;
        tick(3);
        check_all(0, "held_rst_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
